ahb_lite_sram_slave: RTL and testbench
======================================

// Module: ahb_lite_sram_slave
// PURPOSE
//  AHB-Lite slave with word-addressed SRAM. Bench slave for the AHB VIP example:
//  sits directly downstream of the VIP_AHB_BFM_MSTR master (1 master, 1 slave,
//  32-bit bus). Responses: OKAY with programmable wait states, or 2-cycle ERROR.
// PARAMETERS
//  ADDR_WIDTH   32   haddr width
//  DATA_WIDTH   32   hwdata/hrdata width; only 32 supported
//  MEM_DEPTH    256  number of 32-bit words; byte range [0, MEM_DEPTH*4)
//  WAIT_STATES  1    hreadyout-low cycles per OKAY data phase (0..15)
// PORTS
//  hclk       in   1            clock, all logic on rising edge
//  hresetn    in   1            reset, synchronous, active-low
//  hsel       in   1            slave select
//  haddr      in   ADDR_WIDTH   address-phase address
//  htrans     in   2            00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
//  hwrite     in   1            1 = write
//  hsize      in   3            000 byte, 001 half, 010 word; others illegal
//  hburst     in   3            ignored (every beat decoded independently)
//  hwdata     in   DATA_WIDTH   write data, valid in data phase
//  hready     in   1            bus HREADY (previous data phase complete)
//  hreadyout  out  1            slave ready / data phase done
//  hresp      out  1            0 OKAY, 1 ERROR
//  hrdata     out  DATA_WIDTH   read data, valid when hreadyout=1 on a read
// BEHAVIOUR
//  - Transfer accepted when hsel & hready & htrans[1] on a rising edge. Address,
//    size and hwrite are registered into the data phase. IDLE/BUSY or !hsel ->
//    no transfer; the next data phase is zero-wait OKAY.
//  - Error check at acceptance: hsize>010, misaligned (half: addr[0]!=0; word:
//    addr[1:0]!=0), or haddr >= MEM_DEPTH*4 -> ERROR. Memory is not touched.
//  - FSM states: IDLE, WAIT, ERR1, ERR2.
//    IDLE: hreadyout=1, hresp=0. Accept good, WAIT_STATES>0 -> WAIT with
//      counter=WAIT_STATES. Accept good, WAIT_STATES=0 -> stay IDLE; the data
//      phase completes in the next cycle. Accept bad -> ERR1.
//    WAIT: hreadyout=0. Counter decrements each cycle. At 1 -> IDLE; the
//      completion cycle follows with hreadyout=1.
//    ERR1: hreadyout=0, hresp=1 -> ERR2.
//    ERR2: hreadyout=1, hresp=1. A new transfer may be accepted here; it is
//      decoded as from IDLE.
//  - Every transfer's data phase lasts WAIT_STATES+1 cycles. hready is low
//    during the waits, so no new address is accepted until completion.
//  - Write: hwdata sampled in the completion cycle (hreadyout=1). Byte lanes
//    are little-endian: byte -> lane addr[1:0]; half -> lanes {addr[1],0}+{0,1};
//    word -> all lanes. Memory is updated at the end of that cycle.
//  - Read: hrdata = mem[addr>>2], full word, driven in the completion cycle.
//    hrdata = 0 in every other cycle. The master selects the byte lanes.
//  - Back-to-back write then read of the same word: the read's data phase
//    returns the newly written value. Memory is updated before the read
//    data phase completes.
//  - Reset (hresetn=0 at an edge): FSM->IDLE, counter=0, hreadyout=1,
//    hresp=0, hrdata=0. Any in-flight write is discarded. SRAM contents are
//    not reset.
//  - Latency: read data available WAIT_STATES+1 cycles after the address phase.
// TESTING
//  1 WAIT_STATES=1: write word 0xDEADBEEF @0x10, read @0x10 -> hreadyout low
//    1 cycle each, OKAY, hrdata=0xDEADBEEF.
//  2 Byte write 0x5A @0x13 over 0x00000000 @0x10, read word -> 0x5A000000.
//    Half write 0x1234 @0x10 -> 0x5A001234.
//  3 Read @0x400 (MEM_DEPTH=256), then word @0x02, then hsize=011 ->
//    each: hresp=1/hreadyout=0, then hresp=1/hreadyout=1; memory unchanged.
//  4 WAIT_STATES=0, NONSEQ write @0x20 then read @0x20 back-to-back ->
//    zero-wait, read returns the written value.
//  5 hsel=1 with htrans=IDLE/BUSY, and hsel=0 with htrans=NONSEQ ->
//    hreadyout=1, hresp=0, no memory change.
//  6 hresetn low during WAIT of write @0x30 -> next cycle hreadyout=1,
//    hresp=0; later read @0x30 returns the prior contents.

Source files
------------

// File: rtl/ahb_lite_sram_slave_if.sv
// ============================================================================
//  Module   : ahb_lite_sram_slave_if
//  Purpose  : AHB-Lite bus bundle between a single master and the SRAM slave.
//  Ports    : none (signal bundle). Master drives hsel/haddr/htrans/hwrite/
//             hsize/hburst/hwdata/hready; slave drives hreadyout/hresp/hrdata.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface ahb_lite_sram_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  hsel;
  logic [ADDR_WIDTH-1:0] haddr;
  logic [1:0]            htrans;
  logic                  hwrite;
  logic [2:0]            hsize;
  logic [2:0]            hburst;
  logic [DATA_WIDTH-1:0] hwdata;
  logic                  hready;
  logic                  hreadyout;
  logic                  hresp;
  logic [DATA_WIDTH-1:0] hrdata;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
    output hreadyout, hresp, hrdata
  );
endinterface

`default_nettype wire

// File: rtl/ahb_lite_sram_slave.sv
// ============================================================================
//  Module   : ahb_lite_sram_slave
//  Purpose  : AHB-Lite slave backed by a word-addressed SRAM. OKAY responses
//             carry WAIT_STATES wait cycles; illegal transfers get the
//             two-cycle ERROR response and leave memory untouched.
//  Ports    : i_hclk     - clock, rising edge
//             i_hresetn  - synchronous active-low reset
//             io_ahb     - AHB-Lite slave modport (address/control/data in,
//                          hreadyout/hresp/hrdata out)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ahb_lite_sram_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 1
) (
  input  wire logic               i_hclk,
  input  wire logic               i_hresetn,
  ahb_lite_sram_slave_if.slave    io_ahb
);

  localparam int                  C_IDX_W      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int                  C_LANES      = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] C_BYTE_LIMIT = (ADDR_WIDTH + 1)'(MEM_DEPTH * 4);
  localparam logic [3:0]          C_WAIT       = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [3:0]           r_cnt;
  logic [3:0]           w_cnt_nxt;

  // Data-phase context captured at acceptance. r_dp_valid marks a good
  // (non-error) transfer whose data phase has not yet completed.
  logic                 r_dp_valid;
  logic                 r_dp_write;
  logic [C_IDX_W-1:0]   r_dp_idx;
  logic [C_LANES-1:0]   r_dp_be;

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic                 w_hreadyout;
  logic                 w_hresp;
  logic                 w_accept;
  logic                 w_size_bad;
  logic                 w_misalign;
  logic                 w_range_bad;
  logic                 w_bad;
  logic                 w_complete;
  logic [C_LANES-1:0]   w_be;

  // Outputs depend only on registered state, so the acceptance decode below
  // can use hreadyout without forming a combinational loop.
  assign w_hreadyout = (r_state == ST_IDLE) || (r_state == ST_ERR2);
  assign w_hresp     = (r_state == ST_ERR1) || (r_state == ST_ERR2);

  assign w_accept    = io_ahb.hsel && io_ahb.hready && io_ahb.htrans[1] && w_hreadyout;

  assign w_size_bad  = (io_ahb.hsize > 3'b010);
  assign w_misalign  = ((io_ahb.hsize == 3'b001) && io_ahb.haddr[0]) ||
                       ((io_ahb.hsize == 3'b010) && (io_ahb.haddr[1:0] != 2'b00));
  assign w_range_bad = ({1'b0, io_ahb.haddr} >= C_BYTE_LIMIT);
  assign w_bad       = w_size_bad || w_misalign || w_range_bad;

  // A good data phase completes in the first IDLE cycle after acceptance
  // (immediately for zero wait states, after WAIT drains otherwise).
  assign w_complete  = (r_state == ST_IDLE) && r_dp_valid;

  // Little-endian byte-lane enables.
  always_comb begin
    w_be = '1;
    case (io_ahb.hsize[1:0])
      2'b00:   w_be = C_LANES'(4'b0001 << io_ahb.haddr[1:0]);
      2'b01:   w_be = io_ahb.haddr[1] ? C_LANES'(4'b1100) : C_LANES'(4'b0011);
      default: w_be = '1;
    endcase
  end

  // Next-state logic. ERR2 decodes a new transfer exactly as IDLE does.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE, ST_ERR2: begin
        w_state_nxt = ST_IDLE;
        if (w_accept) begin
          if (w_bad) begin
            w_state_nxt = ST_ERR1;
          end else if (C_WAIT != 4'd0) begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = C_WAIT;
          end
        end
      end
      ST_WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ERR1: begin
        w_state_nxt = ST_ERR2;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge i_hclk) begin
    if (!i_hresetn) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 4'd0;
      r_dp_valid <= 1'b0;
      r_dp_write <= 1'b0;
      r_dp_idx   <= '0;
      r_dp_be    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      // A new acceptance in the completion cycle replaces the finished context.
      if (w_accept) begin
        r_dp_valid <= !w_bad;
        r_dp_write <= io_ahb.hwrite;
        r_dp_idx   <= io_ahb.haddr[C_IDX_W+1:2];
        r_dp_be    <= w_be;
      end else if (w_complete) begin
        r_dp_valid <= 1'b0;
      end
    end
  end

  // SRAM write in the completion cycle; a reset at this edge discards it.
  always_ff @(posedge i_hclk) begin
    if (i_hresetn && w_complete && r_dp_write) begin
      for (int b = 0; b < C_LANES; b++) begin
        if (r_dp_be[b]) begin
          r_mem[r_dp_idx][8*b +: 8] <= io_ahb.hwdata[8*b +: 8];
        end
      end
    end
  end

  assign io_ahb.hreadyout = w_hreadyout;
  assign io_ahb.hresp     = w_hresp;
  assign io_ahb.hrdata    = (w_complete && !r_dp_write) ? r_mem[r_dp_idx] : '0;

  // Burst type and the SEQ/NONSEQ distinction do not affect decoding.
  wire w_unused_ok = &{1'b0, io_ahb.htrans[0], io_ahb.hburst};

endmodule

`default_nettype wire

// File: tb/tb_ahb_lite_sram_slave.sv
// ============================================================================
//  Module   : tb_ahb_lite_sram_slave
//  Purpose  : Directed self-checking bench for ahb_lite_sram_slave. Two DUTs:
//             dut1 with one wait state and dut0 with zero wait states.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ahb_lite_sram_slave;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic        hsel1 = 1'b0;
  logic        hsel0 = 1'b0;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = 2'b00;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'b010;
  logic [31:0] hwdata = '0;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  always #5 hclk = ~hclk;

  ahb_lite_sram_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();
  ahb_lite_sram_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();

  assign bus1.hsel   = hsel1;
  assign bus1.haddr  = haddr;
  assign bus1.htrans = htrans;
  assign bus1.hwrite = hwrite;
  assign bus1.hsize  = hsize;
  assign bus1.hburst = 3'b000;
  assign bus1.hwdata = hwdata;
  assign bus1.hready = bus1.hreadyout;

  assign bus0.hsel   = hsel0;
  assign bus0.haddr  = haddr;
  assign bus0.htrans = htrans;
  assign bus0.hwrite = hwrite;
  assign bus0.hsize  = hsize;
  assign bus0.hburst = 3'b000;
  assign bus0.hwdata = hwdata;
  assign bus0.hready = bus0.hreadyout;

  ahb_lite_sram_slave #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(1)
  ) dut1 (
    .i_hclk    (hclk),
    .i_hresetn (hresetn),
    .io_ahb    (bus1)
  );

  ahb_lite_sram_slave #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0)
  ) dut0 (
    .i_hclk    (hclk),
    .i_hresetn (hresetn),
    .io_ahb    (bus0)
  );

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Checks hreadyout/hresp/hrdata of the selected DUT (d0=1 -> dut0).
  task automatic chk_bus(input string tag, input bit d0, input logic rdy,
                         input logic resp, input logic [31:0] rd);
    chk({tag, ".rdy"},  32'(d0 ? bus0.hreadyout : bus1.hreadyout), 32'(rdy));
    chk({tag, ".resp"}, 32'(d0 ? bus0.hresp : bus1.hresp),         32'(resp));
    chk({tag, ".rd"},   d0 ? bus0.hrdata : bus1.hrdata,            rd);
  endtask

  // Single non-pipelined transfer: address phase, then the full data phase.
  task automatic xfer(input string tag, input bit d0, input logic wr,
                      input logic [2:0] sz, input logic [31:0] addr,
                      input logic [31:0] wd, input logic exp_err,
                      input logic [31:0] exp_rd);
    int waits;
    waits  = d0 ? 0 : 1;
    hsel1  = !d0;
    hsel0  = d0;
    htrans = 2'b10;
    hwrite = wr;
    hsize  = sz;
    haddr  = addr;
    tick();
    hsel1  = 1'b0;
    hsel0  = 1'b0;
    htrans = 2'b00;
    hwdata = wd;
    if (exp_err) begin
      chk_bus({tag, ".err1"}, d0, 1'b0, 1'b1, 32'h0);
      tick();
      chk_bus({tag, ".err2"}, d0, 1'b1, 1'b1, 32'h0);
      tick();
    end else begin
      for (int i = 0; i < waits; i++) begin
        chk_bus({tag, ".wait"}, d0, 1'b0, 1'b0, 32'h0);
        tick();
      end
      chk_bus({tag, ".done"}, d0, 1'b1, 1'b0, wr ? 32'h0 : exp_rd);
      tick();
    end
  endtask

  initial begin
    #200000;
    $error("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    hresetn = 1'b0;
    tick();
    tick();
    chk_bus("rst1", 1'b0, 1'b1, 1'b0, 32'h0);
    chk_bus("rst0", 1'b1, 1'b1, 1'b0, 32'h0);
    hresetn = 1'b1;
    tick();

    // 1: word write/read with one wait state
    xfer("t1_wr", 1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
    xfer("t1_rd", 1'b0, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);

    // 2: byte and halfword lane steering
    xfer("t2_clr",  1'b0, 1'b1, 3'b010, 32'h10, 32'h00000000, 1'b0, 32'h0);
    xfer("t2_bwr",  1'b0, 1'b1, 3'b000, 32'h13, 32'h5AAABBCC, 1'b0, 32'h0);
    xfer("t2_brd",  1'b0, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'h5A000000);
    xfer("t2_hwr",  1'b0, 1'b1, 3'b001, 32'h10, 32'hEEEE1234, 1'b0, 32'h0);
    xfer("t2_hrd",  1'b0, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'h5A001234);

    // 3: error responses; memory must stay intact
    xfer("t3_range", 1'b0, 1'b0, 3'b010, 32'h400, 32'h0, 1'b1, 32'h0);
    xfer("t3_align", 1'b0, 1'b1, 3'b010, 32'h02, 32'hFFFFFFFF, 1'b1, 32'h0);
    xfer("t3_size",  1'b0, 1'b1, 3'b011, 32'h10, 32'hFFFFFFFF, 1'b1, 32'h0);
    xfer("t3_rd",    1'b0, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'h5A001234);

    // 5: IDLE/BUSY with hsel, and NONSEQ without hsel, are not transfers
    hsel1  = 1'b1;
    hwrite = 1'b1;
    hsize  = 3'b010;
    haddr  = 32'h10;
    hwdata = 32'h0;
    htrans = 2'b00;
    tick();
    chk_bus("t5_idle", 1'b0, 1'b1, 1'b0, 32'h0);
    htrans = 2'b01;
    tick();
    chk_bus("t5_busy", 1'b0, 1'b1, 1'b0, 32'h0);
    hsel1  = 1'b0;
    htrans = 2'b10;
    tick();
    chk_bus("t5_nosel", 1'b0, 1'b1, 1'b0, 32'h0);
    htrans = 2'b00;
    tick();
    chk_bus("t5_after", 1'b0, 1'b1, 1'b0, 32'h0);
    xfer("t5_rd", 1'b0, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'h5A001234);

    // 6: reset during the wait state discards the write
    xfer("t6_pre", 1'b0, 1'b1, 3'b010, 32'h30, 32'h11112222, 1'b0, 32'h0);
    hsel1  = 1'b1;
    htrans = 2'b10;
    hwrite = 1'b1;
    hsize  = 3'b010;
    haddr  = 32'h30;
    tick();
    hsel1  = 1'b0;
    htrans = 2'b00;
    hwdata = 32'h99999999;
    chk_bus("t6_wait", 1'b0, 1'b0, 1'b0, 32'h0);
    hresetn = 1'b0;
    tick();
    hresetn = 1'b1;
    chk_bus("t6_rst", 1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    xfer("t6_rd", 1'b0, 1'b0, 3'b010, 32'h30, 32'h0, 1'b0, 32'h11112222);

    // 4: zero wait states, pipelined write then read of the same word
    hsel0  = 1'b1;
    htrans = 2'b10;
    hwrite = 1'b1;
    hsize  = 3'b010;
    haddr  = 32'h20;
    tick();
    chk_bus("t4_wr", 1'b1, 1'b1, 1'b0, 32'h0);
    hwdata = 32'hCAFEF00D;
    hwrite = 1'b0;
    tick();
    chk_bus("t4_rd", 1'b1, 1'b1, 1'b0, 32'hCAFEF00D);
    hsel0  = 1'b0;
    htrans = 2'b00;
    tick();
    chk_bus("t4_idle", 1'b1, 1'b1, 1'b0, 32'h0);
    xfer("t4_rd2", 1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 1'b0, 32'hCAFEF00D);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
